// File: rtl/elmt_wise_mult.sv
// Element-wise fixed-point multiplier.
// Loads N_REG signed weights, then multiplies each weight by the matching tap of
// an N_REG-deep sample shift register every time a sample is accepted. The
// product vector is registered with one cycle of latency and held under
// downstream backpressure.
module elmt_wise_mult #(
    parameter int WIDTH = 32,
    parameter int FBITS = 24,
    parameter int N_REG = 31
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             w_restart,
    input  logic                             w_valid,
    input  logic signed [WIDTH-1:0]          w_data,
    output logic                             w_ready,
    input  logic                             x_valid,
    input  logic signed [WIDTH-1:0]          x_data,
    output logic                             x_ready,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic signed [N_REG*WIDTH-1:0]    out_multiply
);

    localparam int CW = (N_REG > 1) ? $clog2(N_REG) : 1;
    localparam int PW = 2 * WIDTH;

    typedef enum logic {
        LOAD_W = 1'b0,
        RUN    = 1'b1
    } state_t;

    state_t                      r_state;
    logic [CW-1:0]               r_wcnt;
    logic signed [WIDTH-1:0]     r_weight [N_REG];
    logic signed [WIDTH-1:0]     r_tap    [N_REG];
    logic                        r_out_valid;
    logic [N_REG*WIDTH-1:0]      r_out_multiply;

    logic                        w_accept;
    logic                        w_wr;
    logic signed [WIDTH-1:0]     w_tap_next [N_REG];
    logic [N_REG*WIDTH-1:0]      w_prod_vec;

    assign w_ready      = (r_state == LOAD_W);
    assign x_ready      = (r_state == RUN) && (!r_out_valid || out_ready);
    assign out_valid    = r_out_valid;
    assign out_multiply = r_out_multiply;

    // A restart wins over a simultaneous weight write or sample accept.
    assign w_accept = x_valid && x_ready && !w_restart;
    assign w_wr     = w_valid && w_ready && !w_restart;

    // Post-shift tap view and per-slot Q-format products.
    for (genvar g = 0; g < N_REG; g++) begin : g_slot
        logic signed [PW-1:0] w_full;

        if (g == 0) begin : g_head
            assign w_tap_next[g] = x_data;
        end else begin : g_body
            assign w_tap_next[g] = r_tap[g-1];
        end

        // Operands are sign-extended to the full product width first.
        assign w_full = PW'(r_weight[g]) * PW'(w_tap_next[g]);
        // Floor shift back to the fixed-point grid, then wrap to WIDTH bits.
        assign w_prod_vec[g*WIDTH +: WIDTH] = WIDTH'(w_full >>> FBITS);
    end

    // Control FSM: weight-load counter, state and output-valid flag.
    always_ff @(posedge clk) begin
        // NOTE: every sequential block uses non-blocking assignments so all
        // registers see pre-edge values regardless of block ordering.
        if (!rst_n) begin
            r_state     <= LOAD_W;
            r_wcnt      <= '0;
            r_out_valid <= 1'b0;
        end else if (w_restart) begin
            r_state     <= LOAD_W;
            r_wcnt      <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end

            case (r_state)
                LOAD_W: begin
                    if (w_wr) begin
                        if (r_wcnt == CW'(N_REG - 1)) begin
                            r_state <= RUN;
                            r_wcnt  <= '0;
                        end else begin
                            r_wcnt  <= r_wcnt + CW'(1);
                        end
                    end
                end
                RUN: begin
                    r_state <= RUN;
                end
                default: begin
                    r_state <= LOAD_W;
                    r_wcnt  <= '0;
                end
            endcase
        end
    end

    // Weight storage, written one word per handshake while loading.
    always_ff @(posedge clk) begin
        // NOTE: the weight array is reset on purpose so the product vector is
        // defined from the first accept; restart deliberately keeps it.
        if (!rst_n) begin
            for (int i = 0; i < N_REG; i++) begin
                r_weight[i] <= '0;
            end
        end else if (w_wr) begin
            r_weight[r_wcnt] <= w_data;
        end
    end

    // Sample shift register and product vector, both advanced only on accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_REG; i++) begin
                r_tap[i] <= '0;
            end
            r_out_multiply <= '0;
        end else if (w_restart) begin
            for (int i = 0; i < N_REG; i++) begin
                r_tap[i] <= '0;
            end
        end else if (w_accept) begin
            for (int i = 0; i < N_REG; i++) begin
                r_tap[i] <= w_tap_next[i];
            end
            r_out_multiply <= w_prod_vec;
        end
    end

endmodule
